rst_seq_gen: RTL and testbench

Parametrised multi-channel reset sequencer with per-channel clock-enable dividers. It derives `NumCh` divided clock enables from one base clock and releases `NumCh` active-low resets in strict channel order. Each channel is held for `RstCycles` pulses of its own divided enable. A synchronous request can re-run the sequence without asserting the global reset. It sits between the testbench/SoC clock-reset source and the subsystems that need ordered reset release in slower clock domains.

---
 rtl/rst_seq_gen.sv | 129 ++++++++++++
 tb/tb_rst_seq_gen.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rst_seq_gen.sv
// Multi-channel reset sequencer: per-channel clock-enable dividers plus an FSM
// that releases the active-low channel resets in ascending order.
module rst_seq_gen #(
  parameter int NumCh     = 2,
  parameter int CntWidth  = 8,
  parameter int RstCycles = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               rst_req_i,
  input  logic [NumCh-1:0][CntWidth-1:0]     div_i,
  output logic [NumCh-1:0]                   clk_en_o,
  output logic [NumCh-1:0]                   rst_no,
  output logic                               done_o
);

  localparam int IdxW  = (NumCh > 1) ? $clog2(NumCh) : 1;
  localparam int PcntW = $clog2(RstCycles + 1);

  localparam logic [IdxW-1:0]     LastIdx  = IdxW'(NumCh - 1);
  localparam logic [PcntW-1:0]    LastPcnt = PcntW'(RstCycles - 1);
  localparam logic [CntWidth-1:0] CntOne   = CntWidth'(1);

  if (NumCh < 1 || CntWidth < 1 || RstCycles < 1) begin : g_bad_param
    $fatal(1, "rst_seq_gen: NumCh, CntWidth and RstCycles must all be >= 1");
  end

  // A zero divisor is treated as divide-by-one.
  function automatic logic [CntWidth-1:0] eff_div(input logic [CntWidth-1:0] d);
    return (d == '0) ? CntOne : d;
  endfunction

  logic [NumCh-1:0][CntWidth-1:0] cnt_q;
  logic [NumCh-1:0][CntWidth-1:0] div_q;

  // div_q == 0 marks "not yet loaded" so the first edge after reset loads it.
  always_comb begin
    clk_en_o = '0;
    for (int c = 0; c < NumCh; c++) begin
      clk_en_o[c] = (div_q[c] != '0) && (cnt_q[c] == div_q[c] - CntOne);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      div_q <= '0;
    end else begin
      for (int c = 0; c < NumCh; c++) begin
        if (div_q[c] == '0 || clk_en_o[c]) begin
          cnt_q[c] <= '0;
          div_q[c] <= eff_div(div_i[c]);
        end else begin
          cnt_q[c] <= cnt_q[c] + CntOne;
        end
      end
    end
  end

  typedef enum logic [1:0] {
    StHold = 2'd0,
    StSeq  = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [PcntW-1:0]  pcnt_q, pcnt_d;
  logic [NumCh-1:0]  rst_q, rst_d;
  logic              done_q, done_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StSeq;
      idx_q   <= '0;
      pcnt_q  <= '0;
      rst_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pcnt_q  <= pcnt_d;
      rst_q   <= rst_d;
      done_q  <= done_d;
    end
  end

  // A request always wins over a release landing on the same edge.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pcnt_d  = pcnt_q;
    rst_d   = rst_q;
    done_d  = done_q;
    if (rst_req_i) begin
      state_d = StHold;
      idx_d   = '0;
      pcnt_d  = '0;
      rst_d   = '0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        StHold: state_d = StSeq;
        StSeq: begin
          if (clk_en_o[idx_q]) begin
            if (pcnt_q == LastPcnt) begin
              rst_d[idx_q] = 1'b1;
              pcnt_d       = '0;
              if (idx_q == LastIdx) begin
                state_d = StDone;
                done_d  = 1'b1;
              end else begin
                idx_d = idx_q + IdxW'(1);
              end
            end else begin
              pcnt_d = pcnt_q + PcntW'(1);
            end
          end
        end
        StDone: state_d = StDone;
        default: state_d = StSeq;
      endcase
    end
  end

  assign rst_no = rst_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_rst_seq_gen.sv
// Bench for rst_seq_gen: cycle-level reference model feeding a scoreboard queue,
// plus per-scenario checks against the timings of the documented test plan.
module tb_rst_seq_gen;
  localparam int NumCh     = 2;
  localparam int CntWidth  = 8;
  localparam int RstCycles = 2;

  logic                           clk = 1'b0;
  logic                           rst_n = 1'b0;
  logic                           req = 1'b0;
  logic [NumCh-1:0][CntWidth-1:0] div;
  logic [NumCh-1:0]               en;
  logic [NumCh-1:0]               rstn;
  logic                           done;

  always #5 clk = ~clk;

  rst_seq_gen #(.NumCh(NumCh), .CntWidth(CntWidth), .RstCycles(RstCycles)) dut (
    .clk_i(clk), .rst_ni(rst_n), .rst_req_i(req), .div_i(div),
    .clk_en_o(en), .rst_no(rstn), .done_o(done)
  );

  typedef struct packed {
    logic [NumCh-1:0] en;
    logic [NumCh-1:0] rst;
    logic             done;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_err = 0;
  int edge_n = 0;

  // Reference model state (0 = HOLD, 1 = SEQ, 2 = DONE)
  int m_cnt[NumCh];
  int m_per[NumCh];
  int m_st, m_idx, m_pc;
  logic [NumCh-1:0] m_rst;
  logic m_done;

  function automatic logic [NumCh-1:0] m_en();
    logic [NumCh-1:0] r;
    for (int c = 0; c < NumCh; c++) r[c] = (m_per[c] != 0) && (m_cnt[c] == m_per[c] - 1);
    return r;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NumCh; c++) begin m_cnt[c] = 0; m_per[c] = 0; end
    m_st = 1; m_idx = 0; m_pc = 0; m_rst = '0; m_done = 1'b0;
  endtask

  task automatic model_edge();
    logic [NumCh-1:0] e;
    e = m_en();
    if (req) begin
      m_st = 0; m_idx = 0; m_pc = 0; m_rst = '0; m_done = 1'b0;
    end else if (m_st == 0) begin
      m_st = 1;
    end else if (m_st == 1 && e[m_idx]) begin
      if (m_pc == RstCycles - 1) begin
        m_rst[m_idx] = 1'b1;
        m_pc = 0;
        if (m_idx == NumCh - 1) begin m_st = 2; m_done = 1'b1; end
        else m_idx++;
      end else begin
        m_pc++;
      end
    end
    for (int c = 0; c < NumCh; c++) begin
      if (m_per[c] == 0 || e[c]) begin
        m_cnt[c] = 0;
        m_per[c] = (div[c] == 0) ? 1 : int'(div[c]);
      end else begin
        m_cnt[c]++;
      end
    end
  endtask

  // Predict the post-edge outputs, push, advance one edge, pop and compare.
  task automatic step(input string tag);
    exp_t x;
    if (rst_n) model_edge();
    x.en = m_en(); x.rst = m_rst; x.done = m_done;
    sb.push_back(x);
    @(posedge clk);
    #1;
    if (rst_n) edge_n++;
    x = sb.pop_front();
    n_cmp++;
    if ({en, rstn, done} !== {x.en, x.rst, x.done}) begin
      n_err++;
      $display("FAIL sb_%s edge %0d: got en=%b rst_n=%b done=%b, expected en=%b rst_n=%b done=%b",
               tag, edge_n, en, rstn, done, x.en, x.rst, x.done);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if ({en, rstn, done} !== '0) begin
      n_err++;
      $display("FAIL async_reset_outputs: got en=%b rst_n=%b done=%b, expected all 0", en, rstn, done);
    end
    step("in_reset");
  endtask

  task automatic release_rst();
    rst_n = 1'b1;
    edge_n = 0;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if ({en, rstn, done} !== '0) begin
      n_err++;
      $display("FAIL reset_state: got en=%b rst_n=%b done=%b, expected all 0", en, rstn, done);
    end
    step("reset_hold");
    step("reset_hold");
  endtask

  task automatic test_basic();
    logic [NumCh-1:0] er;
    div[0] = 8'd1; div[1] = 8'd3;
    do_reset();
    release_rst();
    for (int n = 1; n <= 10; n++) begin
      step("basic");
      er = (n >= 7) ? 2'b11 : (n >= 3) ? 2'b01 : 2'b00;
      n_cmp++;
      if (rstn !== er || done !== (n >= 7)) begin
        n_err++;
        $display("FAIL basic_release edge %0d: got rst_n=%b done=%b, expected rst_n=%b done=%b",
                 n, rstn, done, er, (n >= 7));
      end
      n_cmp++;
      if (en !== {(n % 3 == 0), 1'b1}) begin
        n_err++;
        $display("FAIL basic_clk_en edge %0d: got %b, expected %b", n, en, {(n % 3 == 0), 1'b1});
      end
    end
  endtask

  task automatic test_zero_div();
    div[0] = 8'd0; div[1] = 8'd3;
    do_reset();
    release_rst();
    for (int n = 1; n <= 6; n++) begin
      step("zero_div");
      n_cmp++;
      if (en[0] !== 1'b1 || rstn[0] !== (n >= 3)) begin
        n_err++;
        $display("FAIL zero_div edge %0d: got en0=%b rst_n0=%b, expected en0=1 rst_n0=%b",
                 n, en[0], rstn[0], (n >= 3));
      end
    end
    div[0] = 8'd1;
  endtask

  task automatic test_div_change();
    div[0] = 8'd1; div[1] = 8'd3;
    do_reset();
    release_rst();
    for (int n = 1; n <= 4; n++) step("div_chg_pre");
    div[1] = 8'd5;
    for (int n = 5; n <= 17; n++) begin
      step("div_chg");
      n_cmp++;
      if (en[1] !== (n == 6 || n == 11 || n == 16)) begin
        n_err++;
        $display("FAIL div_change edge %0d: got en1=%b, expected %b", n, en[1], (n == 6 || n == 11 || n == 16));
      end
    end
    div[1] = 8'd3;
  endtask

  task automatic test_rerun();
    int guard;
    guard = 0;
    while (!done && guard < 60) begin step("rerun_wait"); guard++; end
    req = 1'b1;
    step("rerun_req");
    req = 1'b0;
    n_cmp++;
    if (rstn !== '0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL rerun_clear: got rst_n=%b done=%b, expected rst_n=00 done=0", rstn, done);
    end
    guard = 0;
    while (!done && guard < 60) begin step("rerun_seq"); guard++; end
    n_cmp++;
    if (done !== 1'b1 || rstn !== 2'b11) begin
      n_err++;
      $display("FAIL rerun_timeout: got rst_n=%b done=%b after %0d cycles, expected rst_n=11 done=1",
               rstn, done, guard);
    end
  endtask

  task automatic test_collision();
    int guard;
    div[0] = 8'd1; div[1] = 8'd3;
    do_reset();
    release_rst();
    for (int n = 1; n <= 6; n++) step("coll_pre");
    req = 1'b1;
    for (int k = 0; k < 11; k++) begin
      step("coll_hold");
      n_cmp++;
      if (rstn !== '0 || done !== 1'b0) begin
        n_err++;
        $display("FAIL collision_hold cycle %0d: got rst_n=%b done=%b, expected rst_n=00 done=0", k, rstn, done);
      end
    end
    req = 1'b0;
    guard = 0;
    while (!done && guard < 60) begin step("coll_seq"); guard++; end
    n_cmp++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL collision_timeout: got done=%b, expected 1", done);
    end
  endtask

  task automatic test_async();
    logic [NumCh-1:0] er;
    div[0] = 8'd1; div[1] = 8'd3;
    do_reset();
    release_rst();
    for (int n = 1; n <= 4; n++) step("async_pre");
    n_cmp++;
    if (rstn !== 2'b01) begin
      n_err++;
      $display("FAIL async_pre_release: got rst_n=%b, expected 01", rstn);
    end
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if ({en, rstn, done} !== '0) begin
      n_err++;
      $display("FAIL async_mid_seq: got en=%b rst_n=%b done=%b, expected all 0", en, rstn, done);
    end
    step("async_hold");
    release_rst();
    for (int n = 1; n <= 8; n++) begin
      step("async_rerun");
      er = (n >= 7) ? 2'b11 : (n >= 3) ? 2'b01 : 2'b00;
      n_cmp++;
      if (rstn !== er || done !== (n >= 7)) begin
        n_err++;
        $display("FAIL async_rerun edge %0d: got rst_n=%b done=%b, expected rst_n=%b done=%b",
                 n, rstn, done, er, (n >= 7));
      end
    end
  endtask

  initial begin
    div[0] = 8'd1; div[1] = 8'd3;
    model_reset();
    test_reset();
    test_basic();
    test_zero_div();
    test_div_change();
    test_rerun();
    test_collision();
    test_async();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no end, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
